keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix keypad controller. Drives ROWS row lines one at a time, samples COLS column lines and debounces every key with a per-key consecutive-sample counter. Accepted press/release transitions are queued as events in a small FIFO with a valid/ready output. It sits between the board keypad pins and any consumer logic, and replaces one standalone debouncer per key with a single time-shared scan engine.

## Interface
- ROWS, 4, number of row lines (≥1)
- COLS, 4, number of column lines (≥1)
- SCAN_DIV, 8, settle cycles per row with the row driven (≥3)
- STABLE_SCANS, 3, consecutive disagreeing samples needed to flip a key (≥1)
- FIFO_DEPTH, 4, event FIFO entries (≥2, power of two)
- KW, derived, $clog2(ROWS*COLS); key code width

- clk  in  1  clock
- anrst  in  1  asynchronous active-low reset
- ena  in  1  scan enable; low freezes the scanner, FIFO output keeps working
- row_out  out  ROWS  one-hot active-high row drive
- col_in  in  COLS  active-high column sense, asynchronous to clk
- key_state  out  ROWS*COLS  debounced key levels; bit index is row*COLS+col
- evt_valid  out  1  FIFO not empty
- evt_ready  in  1  consumer accepts the head event
- evt_code  out  KW  key index of the head event
- evt_press  out  1  1 = press, 0 = release
- evt_drop  out  1  one-cycle pulse when an event is lost because the FIFO is full

## Operation
- col_in passes through a 2-FF synchronizer (reset 0) before use.
- FSM states, all while ena=1:
  - SETTLE: row_out = onehot(row). Stays SCAN_DIV cycles, then goes to SAMPLE.
  - SAMPLE: 1 cycle. Latches the synchronized columns into samp[COLS-1:0]. Goes to UPDATE with col=0.
  - UPDATE: 1 cycle per column, col = 0..COLS-1. row_out is held during UPDATE.
  - After col=COLS-1: row ← (row==ROWS-1) ? 0 : row+1, then back to SETTLE.
- Per-key update for k = row*COLS+col:
  - If samp[col]==key_state[k]: cnt[k] ← 0.
  - Else if cnt[k]==STABLE_SCANS-1: key_state[k] ← samp[col], cnt[k] ← 0, and push event {k, samp[col]}.
  - Else: cnt[k] ← cnt[k]+1.
- At most one push per cycle, so no push collisions are possible.
- FIFO is first-word-fall-through:
  - Pop when evt_valid && evt_ready.
  - Push is accepted when not full, or when full and a pop happens in the same cycle.
  - Otherwise the event is discarded and evt_drop pulses. key_state still flips.
- ena=0: FSM state, counters, row_out and the synchronizer sampling all hold. Popping continues.
- Reset values: row_out=0, key_state=0, all cnt=0, FIFO empty, evt_valid=0, evt_code=0, evt_press=0, evt_drop=0, FSM=SETTLE, row=0, scan counter=0.
- Reset mid-operation aborts the scan and flushes all queued events. Scanning restarts at row 0.

## Timing
- T_row = SCAN_DIV + 1 + COLS cycles. Frame = ROWS*T_row.
- row_out rises 1 cycle after reset release (registered output).
- SCAN_DIV≥3 ensures the synchronized columns reflect the current row at SAMPLE.
- Event latency after a clean level change: STABLE_SCANS frames, plus up to one extra frame of phase.
- A push in UPDATE cycle n gives evt_valid=1 at cycle n+1 if the FIFO was empty.
- evt_drop is registered and asserts in the cycle after the rejected push.
- Outputs are stable while evt_valid && !evt_ready.

## Configuration
- KEYPAD_SCANNER_MULTI_REJECT_EN defined:
  - In SAMPLE, if popcount(samp) > 1, the whole row sample is discarded.
  - During that row's UPDATE cycles, cnt and key_state hold for all keys in the row.
  - This suppresses ghost keys in unguarded diode-less matrices.
- Macro undefined: every row sample is processed as described in Operation.

## Test plan
- Parameters for all scenarios: ROWS=4, COLS=4, SCAN_DIV=8, STABLE_SCANS=3, FIFO_DEPTH=4; T_row=13, frame=52.
- Press: hold key (1,2) closed -> within 4 frames exactly one event {code=6, press=1}, key_state[6]=1.
- Release: open key (1,2) -> one event {code=6, press=0}.
- Bounce: toggle key 5 every frame for 10 frames, then leave it open -> no events, key_state[5]=0 throughout.
- Backpressure: evt_ready=0, press keys 0, 3, 5, 9, 12 in sequence.
  - -> 4 events queued; the 5th press pulses evt_drop once; key_state[12]=1.
  - Then evt_ready=1 -> codes 0, 3, 5, 9 pop in order; no duplicates.
- Freeze: ena=0 for 100 cycles while key 15 is held -> row_out constant, no events, no counter change.
  - Re-enable -> press event for code 15 follows.
- Reset mid-UPDATE: assert anrst with 2 events queued -> all outputs 0 immediately, FIFO empty.
  - After release, row_out=4'b0001 on the next cycle.
- Macro: hold keys (0,0) and (0,1) together.
  - Macro defined -> no events, key_state=0.
  - Macro undefined -> events with codes 0 then 1, both press=1.

Source files
------------

// File: rtl/keypad_scanner.sv
// Time-shared matrix keypad scanner: per-key debounce and a FWFT press/release event FIFO.
// Optional macro KEYPAD_SCANNER_MULTI_REJECT_EN discards row samples with more than one closed column.
module keypad_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 8,
  parameter int STABLE_SCANS = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int KW           = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 anrst,
  input  logic                 ena,
  output logic [ROWS-1:0]      row_out,
  input  logic [COLS-1:0]      col_in,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KW-1:0]        evt_code,
  output logic                 evt_press,
  output logic                 evt_drop
);

  localparam int NKEYS = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int SW    = (STABLE_SCANS > 1) ? $clog2(STABLE_SCANS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CLW-1:0]   col_q, col_d;
  logic [COLS-1:0]  samp_q, samp_d;
  logic             rej_q, rej_d;
  logic [COLS-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [ROWS-1:0]  row_out_q, row_out_d;
  logic [NKEYS-1:0] key_state_q, key_state_d;
  logic [SW-1:0]    cnt_q [NKEYS];
  logic [SW-1:0]    cnt_d [NKEYS];

  logic [KW-1:0]    key_idx;
  logic             multi_hit;
  logic             push;
  logic [KW-1:0]    push_code;
  logic             push_press;

  logic [KW:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             drop_q, drop_d;
  logic             full, empty, pop, push_ok;
  logic [KW:0]      head;

  assign key_idx = KW'(int'(row_q) * COLS + int'(col_q));

`ifdef KEYPAD_SCANNER_MULTI_REJECT_EN
  // Several closed columns in one row can be a phantom rectangle; drop the whole row sample.
  assign multi_hit = ($countones(sync2_q) > 1);
`else
  assign multi_hit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    row_d       = row_q;
    col_d       = col_q;
    samp_d      = samp_q;
    rej_d       = rej_q;
    sync1_d     = sync1_q;
    sync2_d     = sync2_q;
    row_out_d   = row_out_q;
    key_state_d = key_state_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    push_code   = key_idx;
    push_press  = samp_q[col_q];

    if (ena) begin
      sync1_d = col_in;
      sync2_d = sync1_q;
      case (state_q)
        ST_SETTLE: begin
          if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d   = '0;
            state_d = ST_SAMPLE;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        ST_SAMPLE: begin
          samp_d  = sync2_q;
          rej_d   = multi_hit;
          col_d   = '0;
          state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          if (!rej_q) begin
            if (samp_q[col_q] == key_state_q[key_idx]) begin
              cnt_d[key_idx] = '0;
            end else if (cnt_q[key_idx] == SW'(STABLE_SCANS - 1)) begin
              key_state_d[key_idx] = samp_q[col_q];
              cnt_d[key_idx]       = '0;
              push                 = 1'b1;
            end else begin
              cnt_d[key_idx] = cnt_q[key_idx] + SW'(1);
            end
          end
          if (col_q == CLW'(COLS - 1)) begin
            col_d   = '0;
            row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            state_d = ST_SETTLE;
          end else begin
            col_d = col_q + CLW'(1);
          end
        end
        default: state_d = ST_SETTLE;
      endcase
      row_out_d = ROWS'(1) << row_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; always_comb above uses blocking.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q     <= ST_SETTLE;
      div_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      samp_q      <= '0;
      rej_q       <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      row_out_q   <= '0;
      key_state_q <= '0;
      cnt_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      row_q       <= row_d;
      col_q       <= col_d;
      samp_q      <= samp_d;
      rej_q       <= rej_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      row_out_q   <= row_out_d;
      key_state_q <= key_state_d;
      cnt_q       <= cnt_d;
    end
  end

  // Event FIFO: pointers carry an extra wrap bit to tell full from empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = !empty && evt_ready;
    push_ok  = push && (!full || pop);
    drop_d   = push && !push_ok;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: storage is left unreset; the pointers define validity and the outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= {push_code, push_press};
  end

  assign head      = mem[rd_ptr_q[AW-1:0]];
  assign evt_valid = !empty;
  assign evt_code  = empty ? '0 : head[KW:1];
  assign evt_press = empty ? 1'b0 : head[0];
  assign evt_drop  = drop_q;
  assign row_out   = row_out_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: vector table plus hand-written corner sequences,
// with an event scoreboard compared whenever the DUT hands over an event.
module tb_keypad_scanner;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int NK    = ROWS * COLS;
  localparam int FRAME = 52;

  logic            clk = 1'b0;
  logic            anrst = 1'b0;
  logic            ena = 1'b0;
  logic            evt_ready = 1'b0;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_in;
  logic [NK-1:0]   key_state;
  logic            evt_valid;
  logic [3:0]      evt_code;
  logic            evt_press;
  logic            evt_drop;
  logic [NK-1:0]   keys = '0;

  typedef struct packed {
    logic [3:0] code;
    logic       press;
  } evt_t;

  typedef struct {
    int         key;
    logic       level;
    logic [3:0] exp_code;
    logic       exp_press;
  } vec_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   drop_cnt = 0;

  keypad_scanner dut (
    .clk       (clk),
    .anrst     (anrst),
    .ena       (ena),
    .row_out   (row_out),
    .col_in    (col_in),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .evt_drop  (evt_drop)
  );

  always #5 clk = ~clk;

  // Switch matrix model: a closed key connects its driven row to its column.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row_out[r] && keys[r*COLS+c]) col_in[c] = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_key(input string name, input int k, input logic lvl);
    int n = 0;
    while (key_state[k] !== lvl && n < 6*FRAME) begin
      tick(1);
      n++;
    end
    check(name, key_state[k], lvl);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2*FRAME) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic set_key(input string name, input int k, input logic lvl, input bit expect_evt);
    keys[k] = lvl;
    if (expect_evt) exp_q.push_back('{4'(k), lvl});
    wait_key({name, "_ks"}, k, lvl);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (anrst && evt_drop) drop_cnt++;
    if (anrst && evt_valid && evt_ready) begin
      check("evt_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("evt_code", evt_code, mon_e.code);
        check("evt_press", evt_press, mon_e.press);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    int         bp_keys[5];
    int         d0;
    bit         bounce_hi;
    bit         frz_ok;
    logic [3:0] ro;
    logic [NK-1:0] ks;

    vecs[0] = '{6,  1'b1, 4'd6,  1'b1};
    vecs[1] = '{6,  1'b0, 4'd6,  1'b0};
    vecs[2] = '{10, 1'b1, 4'd10, 1'b1};
    vecs[3] = '{10, 1'b0, 4'd10, 1'b0};
    vecs[4] = '{3,  1'b1, 4'd3,  1'b1};
    vecs[5] = '{3,  1'b0, 4'd3,  1'b0};
    bp_keys = '{0, 3, 5, 9, 12};

    anrst = 1'b0; ena = 1'b1; evt_ready = 1'b1; keys = '0;
    tick(3);
    check("rst_row_out", row_out, 0);
    check("rst_key_state", key_state, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_code", evt_code, 0);
    check("rst_evt_press", evt_press, 0);
    check("rst_evt_drop", evt_drop, 0);
    anrst = 1'b1;
    @(negedge clk);
    check("rel_row_out_0", row_out, 0);
    @(negedge clk);
    check("rel_row_out_1", row_out, 4'b0001);
    tick(1);

    foreach (vecs[i]) begin
      keys[vecs[i].key] = vecs[i].level;
      exp_q.push_back('{vecs[i].exp_code, vecs[i].exp_press});
      wait_key($sformatf("vec%0d_ks", i), vecs[i].key, vecs[i].level);
      wait_drain($sformatf("vec%0d_drain", i));
      tick(2);
    end

    // Bounce: key 5 alternates once per frame and must never be accepted.
    bounce_hi = 1'b0;
    for (int f = 0; f < 10; f++) begin
      keys[5] = (f % 2 == 0);
      repeat (FRAME) begin
        tick(1);
        if (key_state[5]) bounce_hi = 1'b1;
      end
    end
    keys[5] = 1'b0;
    repeat (4*FRAME) begin
      tick(1);
      if (key_state[5]) bounce_hi = 1'b1;
    end
    check("bounce_ks", bounce_hi, 0);
    check("bounce_valid", evt_valid, 0);

    // Backpressure: four events fill the FIFO, the fifth is dropped.
    evt_ready = 1'b0;
    d0 = drop_cnt;
    for (int i = 0; i < 5; i++)
      set_key($sformatf("bp_press%0d", i), bp_keys[i], 1'b1, i < 4);
    tick(3);
    check("bp_drop", drop_cnt - d0, 1);
    check("bp_ks12", key_state[12], 1);
    check("bp_valid", evt_valid, 1);
    check("bp_head", evt_code, 0);
    check("bp_qlen", exp_q.size(), 4);
    evt_ready = 1'b1;
    wait_drain("bp_drain");
    tick(3);
    check("bp_empty", evt_valid, 0);
    for (int i = 0; i < 5; i++) begin
      set_key($sformatf("bp_rel%0d", i), bp_keys[i], 1'b0, 1'b1);
      wait_drain($sformatf("bp_rel%0d_drain", i));
    end

    // Freeze: with ena low nothing moves even though key 15 is closed.
    ena = 1'b0;
    tick(1);
    ro = row_out;
    ks = key_state;
    keys[15] = 1'b1;
    frz_ok = 1'b1;
    repeat (100) begin
      tick(1);
      if (row_out !== ro || key_state !== ks || evt_valid !== 1'b0) frz_ok = 1'b0;
    end
    check("frz_stable", frz_ok, 1);
    ena = 1'b1;
    exp_q.push_back('{4'd15, 1'b1});
    wait_key("frz_ks15", 15, 1'b1);
    wait_drain("frz_drain");
    set_key("frz_rel", 15, 1'b0, 1'b1);
    wait_drain("frz_rel_drain");

    // Reset mid-operation with two queued events.
    evt_ready = 1'b0;
    set_key("rq_k1", 1, 1'b1, 1'b0);
    set_key("rq_k2", 2, 1'b1, 1'b0);
    tick(7);
    check("rq_valid", evt_valid, 1);
    anrst = 1'b0;
    #1;
    check("rq_row_out", row_out, 0);
    check("rq_key_state", key_state, 0);
    check("rq_evt_valid", evt_valid, 0);
    check("rq_evt_code", evt_code, 0);
    check("rq_evt_press", evt_press, 0);
    check("rq_evt_drop", evt_drop, 0);
    keys = '0;
    evt_ready = 1'b1;
    tick(2);
    anrst = 1'b1;
    @(negedge clk);
    check("rq_rel_row_out_0", row_out, 0);
    @(negedge clk);
    check("rq_rel_row_out_1", row_out, 4'b0001);
    tick(4*FRAME);
    check("rq_no_evt", evt_valid, 0);

    // Two keys closed together in row 0.
    keys[0] = 1'b1;
    keys[1] = 1'b1;
`ifdef KEYPAD_SCANNER_MULTI_REJECT_EN
    tick(6*FRAME);
    check("mr_ks", key_state, 0);
    check("mr_valid", evt_valid, 0);
    keys = '0;
    tick(2*FRAME);
`else
    exp_q.push_back('{4'd0, 1'b1});
    exp_q.push_back('{4'd1, 1'b1});
    wait_key("mr_ks0", 0, 1'b1);
    wait_key("mr_ks1", 1, 1'b1);
    wait_drain("mr_drain");
    keys = '0;
    exp_q.push_back('{4'd0, 1'b0});
    exp_q.push_back('{4'd1, 1'b0});
    wait_key("mr_rel0", 0, 1'b0);
    wait_key("mr_rel1", 1, 1'b0);
    wait_drain("mr_rel_drain");
`endif
    tick(5);
    check("final_qlen", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
